// File: rtl/proj_pkg.sv
// -----------------------------------------------------------------------------
// proj_pkg
// Shared definitions for the projection sequencer.
//   proj_state_t      : sequencer state encoding
//   PROJ_NUM_PIXELS   : default pixels per column
//   PROJ_NUM_WEIGHTS  : default total accumulator count
//   PROJ_COLS_SIZE    : default columns per group
// -----------------------------------------------------------------------------
package proj_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      ACCUM = 3'd3,
      DONE  = 3'd4
   } proj_state_t;

   localparam int PROJ_NUM_PIXELS  = 160;
   localparam int PROJ_NUM_WEIGHTS = 240;
   localparam int PROJ_COLS_SIZE   = 8;

endpackage : proj_pkg

// File: rtl/proj_seq.sv
// -----------------------------------------------------------------------------
// proj_seq
// Control sequencer for one full projection pass.  A run clears the
// accumulators, then for each group of COLS_SIZE weights requests a column
// group load, waits for its acknowledge, and strobes the accumulate enable for
// NUM_PIXELS cycles.  After the last group a one-cycle done pulse is issued.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle run request (honoured in IDLE only)
//   abort        in   terminate the current run, no done pulse
//   load_ack     in   requested column group is valid (honoured in LOAD only)
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on successful completion
//   load_req     out  request the column group at weight_iter
//   enable       out  accumulate strobe
//   clear        out  accumulator clear strobe
//   pixel_iter   out  current pixel index
//   weight_iter  out  base index of the current weight group
//   perf_cycles  out  busy-cycle counter (only with PROJ_SEQ_PERF_EN)
//
// Optional feature: define PROJ_SEQ_PERF_EN to add the perf_cycles output,
// which restarts on CLEAR, counts every busy cycle and holds in IDLE.
// -----------------------------------------------------------------------------
module proj_seq
   import proj_pkg::*;
#(
   parameter int NUM_PIXELS  = PROJ_NUM_PIXELS,
   parameter int NUM_WEIGHTS = PROJ_NUM_WEIGHTS,
   parameter int COLS_SIZE   = PROJ_COLS_SIZE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        load_ack,
   output logic        busy,
   output logic        done,
   output logic        load_req,
   output logic        enable,
   output logic        clear,
   output logic [15:0] pixel_iter,
   output logic [7:0]  weight_iter
`ifdef PROJ_SEQ_PERF_EN
   ,
   output logic [31:0] perf_cycles
`endif
);

   // Reject configurations the counters cannot represent.
   if (NUM_PIXELS < 1 || NUM_PIXELS > 65536 ||
       COLS_SIZE < 1 || NUM_WEIGHTS < 1 || NUM_WEIGHTS > 256 ||
       (NUM_WEIGHTS % COLS_SIZE) != 0) begin : g_bad_params
      $error("proj_seq: illegal parameters NUM_PIXELS=%0d NUM_WEIGHTS=%0d COLS_SIZE=%0d",
             NUM_PIXELS, NUM_WEIGHTS, COLS_SIZE);
   end

   localparam logic [15:0] LAST_PIXEL = 16'(NUM_PIXELS - 1);
   localparam logic [7:0]  W_STEP     = 8'(COLS_SIZE);

   proj_state_t state_q, state_d;
   logic [15:0] pixel_q, pixel_d;
   logic [7:0]  weight_q, weight_d;
   logic        last_pixel;
   logic        more_groups;

   assign last_pixel  = (pixel_q == LAST_PIXEL);
   // Compared in int so that NUM_WEIGHTS = 256 does not overflow 8 bits.
   assign more_groups = (int'(weight_q) + COLS_SIZE) < NUM_WEIGHTS;

   always_comb begin
      state_d  = state_q;
      pixel_d  = pixel_q;
      weight_d = weight_q;
      unique case (state_q)
         IDLE: begin
            // Iterators are zeroed on entry so they already read 0 in CLEAR.
            if (start) begin
               state_d  = CLEAR;
               pixel_d  = '0;
               weight_d = '0;
            end
         end
         CLEAR: begin
            state_d = LOAD;
         end
         LOAD: begin
            if (load_ack) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (last_pixel) begin
               pixel_d = '0;
               if (more_groups) begin
                  weight_d = weight_q + W_STEP;
                  state_d  = LOAD;
               end else begin
                  state_d  = DONE;
               end
            end else begin
               pixel_d = pixel_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides every other transition; weight_iter keeps its value.
      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         pixel_d  = '0;
         weight_d = weight_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pixel_q  <= '0;
         weight_q <= '0;
      end else begin
         state_q  <= state_d;
         pixel_q  <= pixel_d;
         weight_q <= weight_d;
      end
   end

   // Outputs are pure decodes of registered state and counters.
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign load_req    = (state_q == LOAD);
   assign enable      = (state_q == ACCUM);
   assign clear       = (state_q == CLEAR);
   assign pixel_iter  = pixel_q;
   assign weight_iter = weight_q;

`ifdef PROJ_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   // The CLEAR cycle is itself busy, so the count restarts at 1 there.
   always_comb begin
      perf_d = perf_q;
      if (state_q == CLEAR) begin
         perf_d = 32'd1;
      end else if (state_q != IDLE) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule : proj_seq

// File: tb/tb_proj_seq.sv
// -----------------------------------------------------------------------------
// tb_proj_seq
// Directed bench for proj_seq.  Instance dut_a uses default parameters,
// instance dut_b uses NUM_PIXELS=4, NUM_WEIGHTS=16, COLS_SIZE=8 with a
// load_ack that arrives in the fourth LOAD cycle.  Outputs are sampled on the
// falling clock edge, inputs change right after that sample.
// -----------------------------------------------------------------------------
module tb_proj_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A (defaults)
   logic        start_a, abort_a, ack_a;
   logic        busy_a, done_a, load_req_a, enable_a, clear_a;
   logic [15:0] pixel_a;
   logic [7:0]  weight_a;
   // Instance B (small)
   logic        start_b, abort_b, ack_b;
   logic        busy_b, done_b, load_req_b, enable_b, clear_b;
   logic [15:0] pixel_b;
   logic [7:0]  weight_b;
`ifdef PROJ_SEQ_PERF_EN
   logic [31:0] perf_a, perf_b;
`endif

   proj_seq dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .load_ack(ack_a),
      .busy(busy_a), .done(done_a), .load_req(load_req_a), .enable(enable_a),
      .clear(clear_a), .pixel_iter(pixel_a), .weight_iter(weight_a)
`ifdef PROJ_SEQ_PERF_EN
      , .perf_cycles(perf_a)
`endif
   );

   proj_seq #(.NUM_PIXELS(4), .NUM_WEIGHTS(16), .COLS_SIZE(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .load_ack(ack_b),
      .busy(busy_b), .done(done_b), .load_req(load_req_b), .enable(enable_b),
      .clear(clear_b), .pixel_iter(pixel_b), .weight_iter(weight_b)
`ifdef PROJ_SEQ_PERF_EN
      , .perf_cycles(perf_b)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Statistics for A
   int busy_cnt, lreq_cnt, en_cnt, done_cnt, clr_cnt, pix_err, proto_err, exp_pix, widx;
   int wseq [0:63];
   logic lreq_prev;
   // Statistics for B
   int busy_b_cnt, lreq_b_cnt, en_b_cnt, done_b_cnt, done_b_cyc, lcnt_b;
   int pix_b [0:15];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic reset_stats();
      busy_cnt = 0; lreq_cnt = 0; en_cnt = 0; done_cnt = 0; clr_cnt = 0;
      pix_err = 0; proto_err = 0; exp_pix = 0; widx = 0; lreq_prev = 1'b0;
      busy_b_cnt = 0; lreq_b_cnt = 0; en_b_cnt = 0; done_b_cnt = 0; done_b_cyc = 0; lcnt_b = 0;
   endtask

   // Advance to the next falling edge and sample both instances.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (busy_a) busy_cnt++;
      if (load_req_a) lreq_cnt++;
      if (done_a) done_cnt++;
      if (clear_a) clr_cnt++;
      if (load_req_a && !lreq_prev && widx < 64) begin
         wseq[widx] = int'(weight_a);
         widx++;
      end
      lreq_prev = load_req_a;
      if (enable_a) begin
         en_cnt++;
         if (int'(pixel_a) != exp_pix) pix_err++;
         exp_pix = (exp_pix == 159) ? 0 : exp_pix + 1;
      end
      if (enable_a && clear_a) proto_err++;
      if (load_req_a && (enable_a || clear_a || done_a)) proto_err++;

      if (busy_b) busy_b_cnt++;
      if (enable_b) begin
         if (en_b_cnt < 16) pix_b[en_b_cnt] = int'(pixel_b);
         en_b_cnt++;
      end
      if (done_b) begin
         done_b_cnt++;
         done_b_cyc = cyc;
      end
      // load_ack for B rises in the fourth consecutive LOAD cycle.
      if (load_req_b) begin
         lreq_b_cnt++;
         lcnt_b++;
      end else begin
         lcnt_b = 0;
      end
      ack_b = load_req_b && (lcnt_b == 4);
   endtask

   task automatic wait_done_a(input int budget, input bit noise, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         start_a = noise && (i % 997 == 400);
         tick();
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      start_a = 1'b0;
   endtask

   // One full default run from IDLE, checking counts and group order.
   task automatic run_full(input string tag, input bit noise);
      bit ok;
      reset_stats();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(6000, noise, ok);
      check({tag, "_done_seen"}, int'(ok), 1);
      repeat (3) tick();
      check({tag, "_busy_cycles"}, busy_cnt, 4832);
      check({tag, "_load_req_cycles"}, lreq_cnt, 30);
      check({tag, "_enable_cycles"}, en_cnt, 4800);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_clear_cycles"}, clr_cnt, 1);
      check({tag, "_pixel_seq_errs"}, pix_err, 0);
      check({tag, "_overlap_errs"}, proto_err, 0);
      check({tag, "_groups"}, widx, 30);
      for (int g = 0; g < 30; g++) check({tag, "_weight_iter_seq"}, wseq[g], 8 * g);
      check({tag, "_idle_busy"}, int'(busy_a), 0);
      check({tag, "_weight_hold"}, int'(weight_a), 232);
`ifdef PROJ_SEQ_PERF_EN
      check({tag, "_perf_cycles"}, int'(perf_a), 4832);
      repeat (5) tick();
      check({tag, "_perf_hold"}, int'(perf_a), 4832);
`endif
   endtask

   initial begin
      bit ok;
      bit found;
      int c0;
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; ack_a = 1'b1;
      start_b = 1'b0; abort_b = 1'b0; ack_b = 1'b0;
      reset_stats();
      repeat (3) tick();

      // Reset state
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_load_req", int'(load_req_a), 0);
      check("rst_enable", int'(enable_a), 0);
      check("rst_clear", int'(clear_a), 0);
      check("rst_pixel_iter", int'(pixel_a), 0);
      check("rst_weight_iter", int'(weight_a), 0);
      rst_n = 1'b1;
      tick();

      // Small configuration with delayed load_ack
      reset_stats();
      start_b = 1'b1;
      c0 = cyc;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 100 && done_b_cnt == 0; i++) tick();
      repeat (2) tick();
      check("small_done_latency", done_b_cyc - c0, 18);
      check("small_busy_cycles", busy_b_cnt, 18);
      check("small_load_req_cycles", lreq_b_cnt, 8);
      check("small_enable_cycles", en_b_cnt, 8);
      check("small_done_pulses", done_b_cnt, 1);
      for (int i = 0; i < 8; i++) check("small_pixel_seq", pix_b[i], i % 4);
      check("small_idle_busy", int'(busy_b), 0);

      // Default run, load_ack tied high
      run_full("req041", 1'b0);

      // Spurious start pulses while busy; load_ack also high outside LOAD
      run_full("req044", 1'b1);

      // Abort in the second group at pixel 50
      reset_stats();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (weight_a == 8'd8 && enable_a && pixel_a == 16'd50) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("abort_point_reached", int'(found), 1);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("abort_busy", int'(busy_a), 0);
      check("abort_enable", int'(enable_a), 0);
      repeat (200) tick();
      check("abort_no_done", done_cnt, 0);
      run_full("after_abort", 1'b0);

      // Abort alone in IDLE does nothing
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      tick();
      check("idle_abort_busy", int'(busy_a), 0);

      // Abort together with start in IDLE starts a run
      reset_stats();
      abort_a = 1'b1;
      start_a = 1'b1;
      tick();
      abort_a = 1'b0;
      start_a = 1'b0;
      check("abort_start_busy", int'(busy_a), 1);
      check("abort_start_clear", int'(clear_a), 1);
      wait_done_a(6000, 1'b0, ok);
      check("abort_start_done", int'(ok), 1);
      repeat (3) tick();

      // Asynchronous reset in the LOAD of the third group
      reset_stats();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (load_req_a && weight_a == 8'd16) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("midload_reached", int'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy_a), 0);
      check("arst_load_req", int'(load_req_a), 0);
      check("arst_enable", int'(enable_a), 0);
      check("arst_clear", int'(clear_a), 0);
      check("arst_done", int'(done_a), 0);
      check("arst_pixel_iter", int'(pixel_a), 0);
      check("arst_weight_iter", int'(weight_a), 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_rst_idle", int'(busy_a), 0);
      run_full("post_rst", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_proj_seq
